rb_mult_share_ctrl: RTL and testbench

//  Sequencer/arbiter sharing one combinational row-bypass array multiplier between two

---
 rtl/rb_mult_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_rb_mult_share_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rb_mult_share_ctrl.sv
// Two-requester sequencer for a shared multicycle array multiplier: arbitrate, launch, settle, capture, return.
// Optional ZERO_SKIP_EN: a zero operand bypasses the array and answers 0 on the next cycle.
//   state  | meaning
//   IDLE   | array operands frozen, waiting for a requester
//   RUN    | operands held while the array settles, count runs down
//   RESP   | product held on resp_* until the consumer takes it
module rb_mult_share_ctrl #(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int SETTLE = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [M-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [M-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [M+N-1:0] resp_product,
  output logic [M-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [M+N-1:0] mul_product,
  output logic           busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [M-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [M+N-1:0] resp_product_q, resp_product_d;
  logic           resp_id_q, resp_id_d;
  logic           resp_valid_q, resp_valid_d;
  logic           rr_last_q, rr_last_d;

  logic           grant;
  logic           accept;
  logic           zero_op;
  logic [M-1:0]   sel_a;
  logic [N-1:0]   sel_b;

  // Contested cycles go to whoever did not win last time.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~rr_last_q;
    accept = rst_n && (state_q == S_IDLE) && (req0_valid || req1_valid);
    sel_a  = grant ? req1_a : req0_a;
    sel_b  = grant ? req1_b : req0_b;
`ifdef ZERO_SKIP_EN
    zero_op = (sel_a == '0) || (sel_b == '0);
`else
    zero_op = 1'b0;
`endif
  end

  assign req0_ready   = accept && !grant;
  assign req1_ready   = accept && grant;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign busy         = (state_q != S_IDLE);

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    resp_product_d = resp_product_q;
    resp_id_d      = resp_id_q;
    resp_valid_d   = resp_valid_q;
    rr_last_d      = rr_last_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          resp_id_d = grant;
          rr_last_d = grant;
          if (zero_op) begin
            // Array is never touched, so its operands keep their old values.
            resp_product_d = '0;
            resp_valid_d   = 1'b1;
            state_d        = S_RESP;
          end else begin
            mul_a_d = sel_a;
            mul_b_d = sel_b;
            count_d = CW'(SETTLE - 1);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (count_q == '0) begin
          resp_product_d = mul_product;
          resp_valid_d   = 1'b1;
          state_d        = S_RESP;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      resp_product_q <= '0;
      resp_id_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      rr_last_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      resp_product_q <= resp_product_d;
      resp_id_q      <= resp_id_d;
      resp_valid_q   <= resp_valid_d;
      rr_last_q      <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_rb_mult_share_ctrl.sv
// Self-checking bench for rb_mult_share_ctrl: transaction-level model compared every cycle plus directed literals.
module tb_rb_mult_share_ctrl;

  localparam int S = 3;
`ifdef ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [15:0] resp_product, mul_product;
  logic [7:0]  mul_a, mul_b;

  rb_mult_share_ctrl #(.M(8), .N(8), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_product(resp_product), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .busy(busy)
  );

  // The shared array itself.
  assign mul_product = {8'b0, mul_a} * {8'b0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one pending op with a due cycle number.
  int          cyc = 0;
  bit          m_known = 0;
  bit          m_pend = 0;
  int          m_due = 0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_out_prod = '0;
  logic        m_out_id = 1'b0;
  logic        m_rr = 1'b1;
  logic [7:0]  m_a = '0, m_b = '0;

  function automatic logic m_grant();
    if (req0_valid && req1_valid) return !m_rr;
    return req1_valid;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1; m_pend = 0; m_a = '0; m_b = '0;
      m_out_prod = '0; m_out_id = 1'b0; m_rr = 1'b1;
    end else if (m_known) begin
      logic g;
      bit   acc, rv, zero;
      g    = m_grant();
      acc  = !m_pend && (req0_valid || req1_valid);
      rv   = m_pend && (cyc >= m_due);
      if (acc) begin
        logic [7:0] a, b;
        a    = g ? req1_a : req0_a;
        b    = g ? req1_b : req0_b;
        zero = SKIP && (a == 0 || b == 0);
        m_pend   = 1;
        m_out_id = g;
        m_rr     = g;
        m_prod   = 16'(a) * 16'(b);
        if (!zero) begin m_a = a; m_b = b; end
        m_due = zero ? cyc + 1 : cyc + S + 1;
      end else if (rv && resp_ready) begin
        m_pend = 0;
      end
    end
    cyc++;
    if (m_pend && cyc == m_due) m_out_prod = m_prod;
  end

  always @(negedge clk) begin
    if (m_known) begin
      logic g;
      bit   idle;
      g    = m_grant();
      idle = !m_pend;
      chk("req0_ready", req0_ready, rst_n && idle && req0_valid && !g);
      chk("req1_ready", req1_ready, rst_n && idle && req1_valid && g);
      chk("resp_valid", resp_valid, m_pend && cyc >= m_due);
      chk("busy", busy, m_pend);
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      chk("resp_product", resp_product, m_out_prod);
      chk("resp_id", resp_id, m_out_id);
    end
  end

  bit rec = 0;
  bit acc_q[$];
  always @(negedge clk) begin
    if (rec && req0_ready) acc_q.push_back(1'b0);
    if (rec && req1_ready) acc_q.push_back(1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and report edges from the accept cycle to resp_valid; resp_ready stays 0.
  task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [15:0] prod);
    bit got = 0;
    lat  = -1;
    prod = '0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
      tick();
    end
    req0_valid = 0;
    req1_valid = 0;
    if (!got) begin
      chk("op_accept_timeout", 0, 1);
      return;
    end
    got = 0;
    for (int i = 1; i < 50 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; lat = i; prod = resp_product; end
      else tick();
    end
    if (!got) chk("op_resp_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 0;
    resp_ready = 1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
    resp_ready = 0;
    tick();
  endtask

  initial begin
    int          lat;
    logic [15:0] prod;
    bit          seen, got;

    rst_n = 0; req0_valid = 1; req1_valid = 1; resp_ready = 0;
    req0_a = 8'd1; req0_b = 8'd2; req1_a = 8'd3; req1_b = 8'd4;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready_both", {req0_ready, req1_ready}, 0);
    chk("rst_mul_a", mul_a, 0);
    tick();
    rst_n = 1; req0_valid = 0; req1_valid = 0;
    tick();

    do_op(0, 8'd13, 8'd11, lat, prod);
    chk("single_lat", lat, 4);
    chk("single_prod", prod, 143);
    chk("single_id", resp_id, 0);
    chk("single_mul_a", mul_a, 13);
    chk("single_mul_b", mul_b, 11);
    tick();
    resp_ready = 1;
    tick();
    resp_ready = 0;
    tick();

    req0_a = 8'd255; req0_b = 8'd255; req1_a = 8'd255; req1_b = 8'd255;
    req0_valid = 1; req1_valid = 1; resp_ready = 1; rec = 1; seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid && !seen) begin
        seen = 1;
        chk("max_prod", resp_product, 65025);
      end
      tick();
    end
    rec = 0; req0_valid = 0; req1_valid = 0;
    chk("contend_seen", seen, 1);
    chk("contend_count", acc_q.size() >= 5, 1);
    if (acc_q.size() > 0) chk("contend_first", acc_q[0], 1);
    for (int i = 1; i < acc_q.size(); i++) chk("contend_alt", acc_q[i], !acc_q[i-1]);
    drain();

    do_op(1, 8'd100, 8'd3, lat, prod);
    chk("bp_first_prod", prod, 300);
    req0_valid = 1; req0_a = 8'd7; req0_b = 8'd7;
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("bp_prod", resp_product, 300);
      chk("bp_id", resp_id, 1);
      chk("bp_busy", busy, 1);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    req0_valid = 0; resp_ready = 1;
    tick();
    resp_ready = 0;
    tick();

    req0_valid = 1; req0_a = 8'd9; req0_b = 8'd9; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
      tick();
    end
    req0_valid = 0;
    chk("mid_accept", got, 1);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    req0_valid = 1; req1_valid = 1;
    req0_a = 8'd77; req0_b = 8'd5; req1_a = 8'd1; req1_b = 8'd1;
    @(negedge clk);
    chk("post_rst_grant0", req0_ready, 1);
    chk("post_rst_grant1", req1_ready, 0);
    chk("post_rst_rv", resp_valid, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    drain();

    do_op(1, 8'd0, 8'd200, lat, prod);
    chk("zs_lat", lat, SKIP ? 1 : 4);
    chk("zs_prod", prod, 0);
    chk("zs_id", resp_id, 1);
    chk("zs_mul_a", mul_a, SKIP ? 77 : 0);
    chk("zs_mul_b", mul_b, SKIP ? 5 : 200);
    resp_ready = 1;
    tick();
    resp_ready = 0;
    tick();

    for (int i = 0; i < 800; i++) begin
      rst_n      = ($urandom_range(0, 79) != 0);
      req0_valid = ($urandom_range(0, 1) != 0);
      req1_valid = ($urandom_range(0, 1) != 0);
      req0_a     = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      req0_b     = 8'($urandom);
      req1_a     = 8'($urandom);
      req1_b     = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      resp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0; resp_ready = 1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
